// File: rtl/fifo_wr_arbiter_rr_if.sv
// Write-side bundle between N single-beat requesters, the round-robin arbiter and the shared FIFO.
// The arbiter takes the master view; producers and the FIFO together form the slave view.
interface fifo_wr_arbiter_rr_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]            req;
    logic [N-1:0][WIDTH-1:0] req_data;
    logic [N-1:0]            req_last;
    logic [N-1:0]            gnt;
    logic                    fifo_full;
    logic                    fifo_write;
    logic [IDW+WIDTH-1:0]    fifo_wdata;
    logic                    locked;
    logic                    lock_abort;

    modport master (
        input  req, req_data, req_last, fifo_full,
        output gnt, fifo_write, fifo_wdata, locked, lock_abort
    );

    modport slave (
        output req, req_data, req_last, fifo_full,
        input  gnt, fifo_write, fifo_wdata, locked, lock_abort
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr.sv
// Round-robin arbiter for the write port of a shared FIFO; each accepted beat is tagged {source ID, data}.
// Define FIFO_ARB_BURST_LOCK_EN to keep the grant with one requester until its req_last beat (with idle timeout).
module fifo_wr_arbiter_rr #(
    parameter int N            = 4,
    parameter int WIDTH        = 32,
    parameter int LOCK_TIMEOUT = 15
) (
    input logic                  clk,
    input logic                  rest,
    fifo_wr_arbiter_rr_if.master bus
);
    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] winner;
    logic [IDW-1:0] sel;
    logic           found;
    logic [N-1:0]   gnt;
    logic           grant_ok;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        if (int'(id) >= N - 1) return '0;
        return id + 1'b1;
    endfunction

    // Grants are masked while reset is held so outputs drop in the same cycle rest falls.
    assign grant_ok = rest && !bus.fifo_full;

    // First requester at or after ptr, wrapping past N-1 back to 0.
    always_comb begin
        int idx;
        // NOTE: every comb output gets a default first, otherwise a missed path infers a latch.
        idx    = 0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && bus.req[idx]) begin
                winner = IDW'(idx);
                found  = 1'b1;
            end
        end
    end

`ifdef FIFO_ARB_BURST_LOCK_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] owner, owner_nxt;
    logic [TW-1:0]  tmo_cnt, tmo_nxt;
    logic           abort_nxt, abort_q;

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        tmo_nxt   = tmo_cnt;
        ptr_nxt   = ptr;
        abort_nxt = 1'b0;
        gnt       = '0;
        sel       = winner;
        case (state)
            IDLE: begin
                if (grant_ok && found) begin
                    gnt[winner] = 1'b1;
                    ptr_nxt     = next_id(winner);
                    if (!bus.req_last[winner]) begin
                        state_nxt = LOCK;
                        owner_nxt = winner;
                        tmo_nxt   = '0;
                    end
                end
            end
            LOCK: begin
                sel = owner;
                if (bus.req[owner]) begin
                    // Owner is active: a FIFO stall only restarts the idle count, never aborts.
                    tmo_nxt = '0;
                    if (grant_ok) begin
                        gnt[owner] = 1'b1;
                        if (bus.req_last[owner]) begin
                            state_nxt = IDLE;
                            ptr_nxt   = next_id(owner);
                        end
                    end
                end else if (tmo_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    ptr_nxt   = next_id(owner);
                    abort_nxt = 1'b1;
                    tmo_nxt   = '0;
                end else begin
                    tmo_nxt = tmo_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state   <= IDLE;
            owner   <= '0;
            tmo_cnt <= '0;
            ptr     <= '0;
            abort_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state   <= state_nxt;
            owner   <= owner_nxt;
            tmo_cnt <= tmo_nxt;
            ptr     <= ptr_nxt;
            abort_q <= abort_nxt;
        end
    end

    assign bus.locked     = (state == LOCK);
    assign bus.lock_abort = abort_q;
`else
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        sel     = winner;
        if (grant_ok && found) begin
            gnt[winner] = 1'b1;
            ptr_nxt     = next_id(winner);
        end
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) ptr <= '0;
        else       ptr <= ptr_nxt;
    end

    assign bus.locked     = 1'b0;
    assign bus.lock_abort = 1'b0;

    // Burst inputs exist on the bus but have no function without the lock feature.
    logic unused_cfg;
    assign unused_cfg = ^{bus.req_last, LOCK_TIMEOUT[0]};
`endif

    assign bus.gnt        = gnt;
    assign bus.fifo_write = |gnt;
    assign bus.fifo_wdata = (|gnt) ? {sel, bus.req_data[sel]} : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter_rr.sv
// Directed bench for fifo_wr_arbiter_rr (N=4, WIDTH=32); burst-lock scenarios run when
// FIFO_ARB_BURST_LOCK_EN is defined.
module tb_fifo_wr_arbiter_rr;
    localparam int N     = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;

    logic clk = 1'b0;
    logic rest;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_rr_if #(.N(N), .WIDTH(WIDTH)) bus ();

    fifo_wr_arbiter_rr #(.N(N), .WIDTH(WIDTH), .LOCK_TIMEOUT(15)) dut (
        .clk (clk),
        .rest(rest),
        .bus (bus.master)
    );

    function automatic logic [WIDTH-1:0] data_of(input int id, input int tag);
        return WIDTH'((id + 1) * 32'h100 + tag);
    endfunction

    task automatic set_req(input logic [N-1:0] r, input logic [N-1:0] last, input logic full);
        bus.req       = r;
        bus.req_last  = last;
        bus.fifo_full = full;
    endtask

    task automatic set_data(input int tag);
        for (int i = 0; i < N; i++) bus.req_data[i] = data_of(i, tag);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rest = 1'b0;
        #1;
        rest = 1'b1;
    endtask

    task automatic test_reset();
        set_req(4'b1111, 4'b1111, 1'b0);
        set_data(0);
        #2;
        total++;
        if (bus.gnt !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt got=%b want=0000", bus.gnt);
        end
        total++;
        if ({bus.fifo_write, bus.locked, bus.lock_abort} !== 3'b000) begin
            bad++; $display("FAIL reset_flags got=%b want=000", {bus.fifo_write, bus.locked, bus.lock_abort});
        end
        total++;
        if (bus.fifo_wdata !== '0) begin
            bad++; $display("FAIL reset_wdata got=%h want=0", bus.fifo_wdata);
        end
        tick();
        rest = 1'b1;
        set_req(4'b0000, 4'b1111, 1'b0);
        @(negedge clk);
        total++;
        if ({bus.gnt, bus.fifo_write} !== 5'b0) begin
            bad++; $display("FAIL idle_no_req got=%b want=00000", {bus.gnt, bus.fifo_write});
        end
        tick();
    endtask

    task automatic test_rr_order();
        int id;
        for (int c = 0; c < 8; c++) begin
            set_data(c);
            set_req(4'b1111, 4'b1111, 1'b0);
            id = c % N;
            @(negedge clk);
            total++;
            if (bus.gnt !== 4'(1 << id)) begin
                bad++; $display("FAIL rr_gnt cyc=%0d got=%b want=%b", c, bus.gnt, 4'(1 << id));
            end
            total++;
            if (bus.fifo_write !== 1'b1) begin
                bad++; $display("FAIL rr_write cyc=%0d got=%b want=1", c, bus.fifo_write);
            end
            total++;
            if (bus.fifo_wdata !== {IDW'(id), data_of(id, c)}) begin
                bad++; $display("FAIL rr_wdata cyc=%0d got=%h want=%h", c, bus.fifo_wdata, {IDW'(id), data_of(id, c)});
            end
            tick();
        end
    endtask

    // Pointer walk: 0 -> 1 -> 2, then ptr=2 with req 0011 picks 0, then 1, then wrap 3 -> 0.
    task automatic test_skip();
        logic [N-1:0] rq  [6] = '{4'b0001, 4'b0010, 4'b0011, 4'b0011, 4'b1000, 4'b1001};
        int           eid [6] = '{0, 1, 0, 1, 3, 0};
        for (int c = 0; c < 6; c++) begin
            set_data(20 + c);
            set_req(rq[c], 4'b1111, 1'b0);
            @(negedge clk);
            total++;
            if (bus.gnt !== 4'(1 << eid[c])) begin
                bad++; $display("FAIL skip_gnt step=%0d got=%b want=%b", c, bus.gnt, 4'(1 << eid[c]));
            end
            total++;
            if (bus.fifo_wdata !== {IDW'(eid[c]), data_of(eid[c], 20 + c)}) begin
                bad++; $display("FAIL skip_wdata step=%0d got=%h want=%h", c, bus.fifo_wdata, {IDW'(eid[c]), data_of(eid[c], 20 + c)});
            end
            tick();
        end
    endtask

    // ptr=1 on entry; three full cycles must not move it.
    task automatic test_full();
        set_data(40);
        for (int c = 0; c < 3; c++) begin
            set_req(4'b1111, 4'b1111, 1'b1);
            @(negedge clk);
            total++;
            if ({bus.gnt, bus.fifo_write} !== 5'b0) begin
                bad++; $display("FAIL full_stall cyc=%0d got=%b want=00000", c, {bus.gnt, bus.fifo_write});
            end
            total++;
            if (bus.fifo_wdata !== '0) begin
                bad++; $display("FAIL full_wdata cyc=%0d got=%h want=0", c, bus.fifo_wdata);
            end
            tick();
        end
        set_req(4'b1111, 4'b1111, 1'b0);
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0010) begin
            bad++; $display("FAIL full_resume got=%b want=0010", bus.gnt);
        end
        tick();
        set_req(4'b0000, 4'b1111, 1'b0);
    endtask

`ifdef FIFO_ARB_BURST_LOCK_EN
    task automatic test_burst_lock();
        pulse_reset();
        set_data(50);
        set_req(4'b0001, 4'b1111, 1'b0);
        tick();
        for (int b = 0; b < 3; b++) begin
            bus.req_data[0] = 32'h55;
            bus.req_data[1] = 32'hA + b;
            set_req(4'b0011, (b == 2) ? 4'b1111 : 4'b1101, 1'b0);
            @(negedge clk);
            total++;
            if (bus.gnt !== 4'b0010) begin
                bad++; $display("FAIL burst_gnt beat=%0d got=%b want=0010", b, bus.gnt);
            end
            total++;
            if (bus.fifo_wdata !== {2'd1, 32'(32'hA + b)}) begin
                bad++; $display("FAIL burst_wdata beat=%0d got=%h want=%h", b, bus.fifo_wdata, {2'd1, 32'(32'hA + b)});
            end
            total++;
            if (bus.locked !== (b > 0)) begin
                bad++; $display("FAIL burst_locked beat=%0d got=%b want=%b", b, bus.locked, (b > 0));
            end
            tick();
        end
        set_req(4'b0011, 4'b1111, 1'b0);
        @(negedge clk);
        total++;
        if ({bus.gnt, bus.locked} !== 5'b00010) begin
            bad++; $display("FAIL burst_release got=%b want=00010", {bus.gnt, bus.locked});
        end
        tick();
        set_req(4'b0000, 4'b1111, 1'b0);
    endtask

    task automatic test_lock_timeout();
        pulse_reset();
        set_data(60);
        set_req(4'b1100, 4'b1011, 1'b0);
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0100) begin
            bad++; $display("FAIL tmo_first got=%b want=0100", bus.gnt);
        end
        tick();
        // Owner idle 5 cycles, then a FIFO-stalled request restarts the count.
        for (int c = 0; c < 6; c++) begin
            if (c < 5) set_req(4'b1000, 4'b1011, 1'b0);
            else       set_req(4'b1100, 4'b1011, 1'b1);
            @(negedge clk);
            total++;
            if ({bus.gnt, bus.locked, bus.lock_abort} !== 6'b000010) begin
                bad++; $display("FAIL tmo_hold cyc=%0d got=%b want=000010", c, {bus.gnt, bus.locked, bus.lock_abort});
            end
            tick();
        end
        for (int c = 0; c < 15; c++) begin
            set_req(4'b1000, 4'b1011, 1'b0);
            @(negedge clk);
            total++;
            if ({bus.gnt, bus.locked, bus.lock_abort} !== 6'b000010) begin
                bad++; $display("FAIL tmo_count cyc=%0d got=%b want=000010", c, {bus.gnt, bus.locked, bus.lock_abort});
            end
            tick();
        end
        @(negedge clk);
        total++;
        if ({bus.gnt, bus.locked, bus.lock_abort} !== 6'b100001) begin
            bad++; $display("FAIL tmo_abort got=%b want=100001", {bus.gnt, bus.locked, bus.lock_abort});
        end
        tick();
        set_req(4'b0000, 4'b1111, 1'b0);
        @(negedge clk);
        total++;
        if (bus.lock_abort !== 1'b0) begin
            bad++; $display("FAIL tmo_pulse got=%b want=0", bus.lock_abort);
        end
        tick();
    endtask
`endif

    task automatic test_reset_midburst();
        pulse_reset();
        set_data(70);
        set_req(4'b0010, 4'b1111, 1'b0);
        tick();
        set_req(4'b0101, 4'b1011, 1'b0);
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0100) begin
            bad++; $display("FAIL mid_prime got=%b want=0100", bus.gnt);
        end
        tick();
`ifdef FIFO_ARB_BURST_LOCK_EN
        total++;
        if (bus.locked !== 1'b1) begin
            bad++; $display("FAIL mid_locked got=%b want=1", bus.locked);
        end
`endif
        rest = 1'b0;
        #1;
        total++;
        if ({bus.gnt, bus.fifo_write, bus.locked, bus.lock_abort} !== 7'b0) begin
            bad++; $display("FAIL mid_reset got=%b want=0000000", {bus.gnt, bus.fifo_write, bus.locked, bus.lock_abort});
        end
        tick();
        rest = 1'b1;
        set_req(4'b0101, 4'b1111, 1'b0);
        @(negedge clk);
        total++;
        if (bus.gnt !== 4'b0001 || bus.fifo_wdata !== {2'd0, data_of(0, 70)}) begin
            bad++; $display("FAIL mid_after got=%b/%h want=0001/%h", bus.gnt, bus.fifo_wdata, {2'd0, data_of(0, 70)});
        end
        tick();
        set_req(4'b0000, 4'b1111, 1'b0);
    endtask

    initial begin
        rest = 1'b0;
        set_req(4'b0000, 4'b1111, 1'b0);
        set_data(0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rr_order();
        test_skip();
        test_full();
`ifdef FIFO_ARB_BURST_LOCK_EN
        test_burst_lock();
        test_lock_timeout();
`endif
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
